// File: rtl/mcash_pkg.sv
// Shared types and opcodes for the cache channel responder and its return FIFO.
package mcash_pkg;

  typedef logic [2:0]   op_t;
  typedef logic [127:0] line_t;
  typedef logic [27:0]  laddr_t;

  localparam op_t OP_RD = 3'b001;
  localparam op_t OP_WR = 3'b010;

  // True when any line-address bit above the index field is set.
  function automatic logic addr_oor(input laddr_t addr, input int idx_w);
    return (addr >> idx_w) != 28'd0;
  endfunction

endpackage

// File: rtl/mcash_rtn_fifo.sv
// Return-data FIFO: power-of-two depth, wrapping pointers, storage cleared on reset
// so the head reads as zero until the first push.
module mcash_rtn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [PW:0]      cnt_q;
  logic [PW:0]      cnt_d;
  logic [WIDTH-1:0] buf_q [DEPTH];

  always_comb begin
    cnt_d = cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        buf_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + PW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = buf_q[rd_q];

endmodule

// File: rtl/mcash_ch_resp.sv
// Cache channel responder: line memory, fixed-latency read pipeline, credit-based
// request flow control. Optional MCASH_RESP_OOR_CHK_EN flags out-of-range addresses.
module mcash_ch_resp
  import mcash_pkg::*;
#(
  parameter int IDX_W     = 6,
  parameter int LAT       = 2,
  parameter int RTN_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_allowIn_o,
  input  logic [2:0]   req_op_i,
  input  logic [27:0]  req_addr_i,
  input  logic [127:0] req_data_i,
  output logic         rtn_valid_o,
  input  logic         rtn_ready_i,
  output logic [127:0] rtn_data_o,
  output logic         err_o
);

  localparam int CNT_W = $clog2(RTN_DEPTH) + 1;
  // The accept cycle acts as the first stage, so LAT-1 registers give LAT cycles to valid.
  localparam int PN    = (LAT > 1) ? LAT - 1 : 1;

  line_t             mem_q [2**IDX_W];
  logic [PN-1:0]     pv_q;
  line_t             pd_q [PN];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              allow_q;

  op_t               op_s;
  logic [IDX_W-1:0]  idx_s;
  logic              acc_s;
  logic              rd_acc_s;
  logic              wr_en_s;
  logic              oor_s;
  line_t             rd_data_s;
  logic              push_v_s;
  line_t             push_d_s;
  logic              fifo_valid_s;
  logic              pop_s;

  assign op_s      = op_t'(req_op_i);
  assign idx_s     = req_addr_i[IDX_W-1:0];
  assign acc_s     = req_valid_i & allow_q & rst_i;
  assign rd_acc_s  = acc_s & (op_s == OP_RD);
  assign wr_en_s   = acc_s & (op_s == OP_WR) & ~oor_s;
  assign rd_data_s = oor_s ? 128'd0 : mem_q[idx_s];
  assign pop_s     = fifo_valid_s & rtn_ready_i;

`ifdef MCASH_RESP_OOR_CHK_EN
  logic err_q;

  assign oor_s = addr_oor(req_addr_i, IDX_W);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (acc_s & oor_s);
    end
  end

  assign err_o = err_q;
`else
  assign oor_s = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[idx_s] <= req_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= rd_acc_s;
      pd_q[0] <= rd_data_s;
      for (int k = 1; k < PN; k++) begin
        pv_q[k] <= pv_q[k-1];
        pd_q[k] <= pd_q[k-1];
      end
    end
  end

  generate
    if (LAT == 1) begin : g_direct
      assign push_v_s = rd_acc_s;
      assign push_d_s = rd_data_s;
    end else begin : g_piped
      assign push_v_s = pv_q[PN-1];
      assign push_d_s = pd_q[PN-1];
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q + CNT_W'(rd_acc_s) - CNT_W'(pop_s);
  end

  // Credit counter covers pipeline plus FIFO, so a push never meets a full FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      allow_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      allow_q <= (cnt_d < CNT_W'(RTN_DEPTH));
    end
  end

  mcash_rtn_fifo #(
    .DEPTH (RTN_DEPTH),
    .WIDTH (128)
  ) u_rtn_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_v_s),
    .push_data_i (push_d_s),
    .pop_i       (pop_s),
    .valid_o     (fifo_valid_s),
    .data_o      (rtn_data_o)
  );

  assign rtn_valid_o   = fifo_valid_s;
  assign req_allowIn_o = allow_q;

endmodule
